wb_arbiter: RTL

- Writeback stage directly upstream of the 8x16 register file; drives its single write port (we, addrR, dataR).
- Merges two result sources into one registered write per cycle: the ALU result path (stallable) and the memory load-return path (buffered in a small FIFO).
- Arbitrates with memory-first priority and a bounded-starvation guarantee for the ALU.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types: default widths, the FIFO entry layout and the grant-source select.
package wb_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_ALU  = 2'd1,
      SRC_MEM  = 2'd2
   } wb_src_t;
endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer: head is visible combinationally, pushes/pops take effect at the clock edge.
// Push is refused when full even if a pop happens in the same cycle; pop on empty is ignored.
module wb_fifo import wb_pkg::*; #(
   parameter int  DEPTH = 2,
   parameter type T     = wb_entry_t,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  T                 push_dat_i,
   input  logic             pop_i,
   output T                 pop_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign do_push   = push_i & ~full_o;
   assign do_pop    = pop_i & ~empty_o;
   assign pop_dat_o = mem_q[rd_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat_i;
   end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback merge of ALU and load results onto the register-file port; ALU 1 cycle, loads >=2 cycles.
// Loads win unless the ALU has stalled STARVE_LIMIT cycles; WB_STALL_CNT_EN adds a stall_count output.
module wb_arbiter import wb_pkg::*; #(
   parameter int DATA_W       = wb_pkg::DATA_W,
   parameter int ADDR_W       = wb_pkg::ADDR_W,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              busy
`ifdef WB_STALL_CNT_EN
   ,
   output logic [15:0]       stall_count
`endif
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   entry_t            mem_in, mem_head;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   wb_src_t           src;
   logic              starve_sat;
   logic [SC_W-1:0]   starve_q, starve_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;

   assign mem_in    = '{addr: mem_addr, data: mem_data};
   assign mem_ready = ~fifo_full;

   wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (mem_valid & mem_ready),
      .push_dat_i (mem_in),
      .pop_i      (src == SRC_MEM),
      .pop_dat_o  (mem_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   assign starve_sat = (starve_q == SC_W'(STARVE_LIMIT));

   always_comb begin
      src = SRC_NONE;
      if (starve_sat && alu_valid) src = SRC_ALU;
      else if (!fifo_empty)        src = SRC_MEM;
      else if (alu_valid)          src = SRC_ALU;
   end

   // Gated by reset so a held reset never reports an accepted ALU result.
   assign alu_ready = reset & (src == SRC_ALU);

   always_comb begin
      starve_d = starve_q;
      if (!alu_valid || alu_ready) starve_d = '0;
      else if (!starve_sat)        starve_d = starve_q + 1'b1;

      rf_we_d   = (src != SRC_NONE);
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      case (src)
         SRC_ALU: begin
            rf_addr_d = alu_addr;
            rf_data_d = alu_data;
         end
         SRC_MEM: begin
            rf_addr_d = mem_head.addr;
            rf_data_d = mem_head.data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q  <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         starve_q  <= starve_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_data = rf_data_q;
   assign busy    = (fifo_count != '0) | rf_we_q;

`ifdef WB_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [16:0] stall_sum;

   always_comb begin
      stall_sum   = {1'b0, stall_cnt_q} + 17'(alu_valid & ~alu_ready) + 17'(mem_valid & ~mem_ready);
      stall_cnt_d = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_count = stall_cnt_q;
`else
   // Stall statistics are compiled out in this build.
`endif
endmodule
